// File: rtl/alu_pipe_status_if.sv
// alu_pipe_status_if: operand/result handshake bundle between the register-file read stage,
// the ALU and writeback; master drives operands and consumes results.
interface alu_pipe_status_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic [2:0]       ALUop;
  logic             setf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [2:0]       Z;
  logic [2:0]       status;

  modport master (
    output in_valid, Ain, Bin, ALUop, setf, out_ready,
    input  in_ready, out_valid, out, Z, status
  );

  modport slave (
    input  in_valid, Ain, Bin, ALUop, setf, out_ready,
    output in_ready, out_valid, out, Z, status
  );
endinterface

// File: rtl/alu_pipe_status.sv
// alu_pipe_status: registered ALU, one result plus zero/neg/ovf flags per accepted op; sticky status.
// Latency 1, throughput 1 (ALU_MUL_EN: op 110 multiplies over MUL_CYC cycles with in_ready low).
// Backpressure: while a result waits with out_ready low, in_ready is low and out/Z hold.
module alu_pipe_status #(
  parameter int WIDTH   = 16,
  parameter int MUL_CYC = WIDTH
) (
  input logic              clk,
  input logic              reset,
  alu_pipe_status_if.slave bus
);

  if (WIDTH < 2 || MUL_CYC < 1 || MUL_CYC > WIDTH) begin : g_param_check
    $error("alu_pipe_status: WIDTH must be >= 2 and MUL_CYC in 1..WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    HOLD
`ifdef ALU_MUL_EN
    , MUL
`endif
  } state_t;

  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
  } flags_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q;
  flags_t           z_q, status_q;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;
  logic             ld;
  logic [WIDTH-1:0] res_d;
  flags_t           flg_d;
  logic             setf_d;

  assign bus.in_ready  = !reset && ((state_q == IDLE) || (state_q == HOLD && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out       = out_q;
  assign bus.Z         = z_q;
  assign bus.status    = status_q;

  // Single-cycle ops; 110 falls through to pass-B, the multiplier path overrides it when present.
  always_comb begin
    alu_res   = bus.Bin;
    alu_flags = '0;
    case (bus.ALUop)
      OP_ADD: begin
        alu_res       = bus.Ain + bus.Bin;
        alu_flags.ovf = (bus.Ain[WIDTH-1] == bus.Bin[WIDTH-1]) &&
                        (alu_res[WIDTH-1] != bus.Ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res       = bus.Ain - bus.Bin;
        alu_flags.ovf = (bus.Ain[WIDTH-1] != bus.Bin[WIDTH-1]) &&
                        (alu_res[WIDTH-1] != bus.Ain[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.Ain & bus.Bin;
      OP_NOTB: alu_res = ~bus.Bin;
      OP_OR:   alu_res = bus.Ain | bus.Bin;
      OP_XOR:  alu_res = bus.Ain ^ bus.Bin;
      default: alu_res = bus.Bin;
    endcase
    alu_flags.neg  = alu_res[WIDTH-1];
    alu_flags.zero = (alu_res == '0);
  end

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b110;
  // Each MUL cycle retires STEP multiplier bits so the product is complete after MUL_CYC cycles.
  localparam int STEP = (WIDTH + MUL_CYC - 1) / MUL_CYC;
  localparam int CW   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               mul_setf_q;
  flags_t             mul_flags;

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
    end
    mul_flags.ovf  = |acc_d[2*WIDTH-1:WIDTH];
    mul_flags.neg  = acc_d[WIDTH-1];
    mul_flags.zero = (acc_d[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      mul_setf_q <= 1'b0;
    end else if (accept && bus.ALUop == OP_MUL) begin
      acc_q      <= '0;
      mcand_q    <= {{WIDTH{1'b0}}, bus.Ain};
      mplier_q   <= bus.Bin;
      cnt_q      <= '0;
      mul_setf_q <= bus.setf;
    end else if (state_q == MUL) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << STEP;
      mplier_q <= mplier_q >> STEP;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    res_d   = alu_res;
    flg_d   = alu_flags;
    setf_d  = bus.setf;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (bus.ALUop == OP_MUL) begin
            state_d = MUL;
          end else begin
            state_d = HOLD;
            ld      = 1'b1;
          end
`else
          state_d = HOLD;
          ld      = 1'b1;
`endif
        end else if (state_q == HOLD && bus.out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (cnt_q == CW'(MUL_CYC - 1)) begin
          state_d = HOLD;
          ld      = 1'b1;
          res_d   = acc_d[WIDTH-1:0];
          flg_d   = mul_flags;
          setf_d  = mul_setf_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      z_q      <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld) begin
        out_q <= res_d;
        z_q   <= flg_d;
        if (setf_d) status_q <= flg_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_status.sv
// Directed bench for alu_pipe_status: flags, status stickiness, back-to-back, backpressure, multiply, reset.
module tb_alu_pipe_status;
  localparam int WIDTH   = 16;
  localparam int MUL_CYC = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe_status_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe_status #(.WIDTH(WIDTH), .MUL_CYC(MUL_CYC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic sf);
    bus.in_valid = v;
    bus.ALUop    = op;
    bus.Ain      = a;
    bus.Bin      = b;
    bus.setf     = sf;
  endtask

  // {out_valid, out, Z, status}
  function automatic logic [22:0] snap();
    return {bus.out_valid, bus.out, bus.Z, bus.status};
  endfunction

  task automatic test_reset();
    logic [22:0] exp;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    step();
    step();
    exp = {1'b0, 16'h0000, 3'b000, 3'b000};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL reset_outputs got %h want %h", snap(), exp); end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    reset = 1'b0;
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add_overflow();
    logic [22:0] exp;
    drive(1'b1, 3'b000, 16'h7FFF, 16'h0001, 1'b1);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    exp = {1'b1, 16'h8000, 3'b110, 3'b110};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL add_ovf got %h want %h", snap(), exp); end
    step();
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL add_retire got %b want 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_sub_status();
    logic [22:0] exp;
    drive(1'b1, 3'b001, 16'h0005, 16'h0005, 1'b0);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    exp = {1'b1, 16'h0000, 3'b001, 3'b110};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL sub_zero_nosetf got %h want %h", snap(), exp); end
    drive(1'b1, 3'b001, 16'h8000, 16'h0001, 1'b1);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    exp = {1'b1, 16'h7FFF, 3'b100, 3'b100};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL sub_ovf got %h want %h", snap(), exp); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [22:0] exp;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b011, 16'h0000, 16'h00FF, 1'b0);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy0 got %b want 1", bus.in_ready); end
    step();
    exp = {1'b1, 16'hFF00, 3'b010, 3'b100};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL b2b_not got %h want %h", snap(), exp); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy1 got %b want 1", bus.in_ready); end
    drive(1'b1, 3'b010, 16'hF0F0, 16'h0FF0, 1'b0);
    step();
    exp = {1'b1, 16'h00F0, 3'b000, 3'b100};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL b2b_and got %h want %h", snap(), exp); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy2 got %b want 1", bus.in_ready); end
    drive(1'b1, 3'b100, 16'h1200, 16'h0034, 1'b0);
    step();
    exp = {1'b1, 16'h1234, 3'b000, 3'b100};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL b2b_or got %h want %h", snap(), exp); end
    drive(1'b1, 3'b111, 16'h1111, 16'h0000, 1'b0);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    exp = {1'b1, 16'h0000, 3'b001, 3'b100};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL b2b_passb got %h want %h", snap(), exp); end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [22:0] exp;
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 16'h0001, 16'h0002, 1'b0);
    step();
    drive(1'b1, 3'b101, 16'hAAAA, 16'hFFFF, 1'b0);
    exp = {1'b1, 16'h0003, 3'b000, 3'b100};
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({snap(), bus.in_ready} !== {exp, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold%0d got %h want %h", k, {snap(), bus.in_ready}, {exp, 1'b0});
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got %b want 1", bus.in_ready); end
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    exp = {1'b1, 16'h5555, 3'b000, 3'b100};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL bp_xor got %h want %h", snap(), exp); end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_mul();
    logic [22:0] exp;
    bus.out_ready = 1'b1;
`ifdef ALU_MUL_EN
    drive(1'b1, 3'b110, 16'h0003, 16'h0004, 1'b1);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < MUL_CYC; k++) begin
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
        n_fail++; $display("FAIL mul1_busy%0d got %b want 00", k, {bus.out_valid, bus.in_ready});
      end
      step();
    end
    exp = {1'b1, 16'h000C, 3'b000, 3'b000};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL mul_3x4 got %h want %h", snap(), exp); end
    drive(1'b1, 3'b110, 16'h0100, 16'h0100, 1'b1);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    for (int k = 0; k < MUL_CYC; k++) begin
      n_checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
        n_fail++; $display("FAIL mul2_busy%0d got %b want 00", k, {bus.out_valid, bus.in_ready});
      end
      step();
    end
    exp = {1'b1, 16'h0000, 3'b101, 3'b101};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL mul_ovf got %h want %h", snap(), exp); end
`else
    drive(1'b1, 3'b110, 16'h1234, 16'h8001, 1'b1);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    exp = {1'b1, 16'h8001, 3'b010, 3'b010};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL op110_passb got %h want %h", snap(), exp); end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    logic [22:0] exp;
    int          seen;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'b001, 16'h0001, 16'h0002, 1'b1);
    step();
    exp = {1'b1, 16'hFFFF, 3'b010, 3'b010};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL sub_neg got %h want %h", snap(), exp); end
`ifdef ALU_MUL_EN
    drive(1'b1, 3'b110, 16'h0003, 16'h0003, 1'b1);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    repeat (5) step();
`else
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 16'h4000, 16'h4000, 1'b1);
    step();
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
    step();
    step();
`endif
    reset = 1'b1;
    step();
    exp = {1'b0, 16'h0000, 3'b000, 3'b000};
    n_checks++;
    if (snap() !== exp) begin n_fail++; $display("FAIL midreset_outputs got %h want %h", snap(), exp); end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_rdy got %b want 0", bus.in_ready); end
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    seen          = 0;
    repeat (MUL_CYC + 3) begin
      step();
      if (bus.out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_result got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_status();
    test_back_to_back();
    test_backpressure();
    test_mul();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
